// File: rtl/control_multiciclo_pkg.sv
// Shared constants for the multicycle MIPS control unit: opcodes, state
// encoding and datapath mux select codes.
package control_multiciclo_pkg;

    localparam logic [5:0] OP_TIPO_R = 6'b000000;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SW     = 6'b101011;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_J      = 6'b000010;

    localparam logic [3:0] ST_INICIO   = 4'd0;
    localparam logic [3:0] ST_FETCH    = 4'd1;
    localparam logic [3:0] ST_DECODE   = 4'd2;
    localparam logic [3:0] ST_MEM_DIR  = 4'd3;
    localparam logic [3:0] ST_MEM_LEER = 4'd4;
    localparam logic [3:0] ST_MEM_WB   = 4'd5;
    localparam logic [3:0] ST_MEM_ESCR = 4'd6;
    localparam logic [3:0] ST_EJEC     = 4'd7;
    localparam logic [3:0] ST_ALU_WB   = 4'd8;
    localparam logic [3:0] ST_RAMA     = 4'd9;
    localparam logic [3:0] ST_SALTO    = 4'd10;

    localparam logic [1:0] ALU_SUMA  = 2'b00;
    localparam logic [1:0] ALU_RESTA = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] FB_REG_B      = 2'b00;
    localparam logic [1:0] FB_CUATRO     = 2'b01;
    localparam logic [1:0] FB_INMED      = 2'b10;
    localparam logic [1:0] FB_INMED_DESP = 2'b11;

    localparam logic [1:0] PCF_ALU    = 2'b00;
    localparam logic [1:0] PCF_ALUOUT = 2'b01;
    localparam logic [1:0] PCF_SALTO  = 2'b10;

    function automatic logic opcode_valido(input logic [5:0] op);
        logic ok;
        case (op)
            OP_TIPO_R, OP_LW, OP_SW, OP_BEQ, OP_J: ok = 1'b1;
            default:                               ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/control_multiciclo_contador.sv
// Retired-instruction counter; wraps naturally modulo 2^ANCHO_CONT.
module contador_instrucciones #(
    parameter int ANCHO_CONT = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  inc,
    output logic [ANCHO_CONT-1:0] cuenta
);

    localparam logic [ANCHO_CONT-1:0] UNO = {{(ANCHO_CONT-1){1'b0}}, 1'b1};

    // Count register, cleared by reset, stepped once per retired instruction.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cuenta <= '0;
        end else if (inc) begin
            cuenta <= cuenta + UNO;
        end else begin
            cuenta <= cuenta;
        end
    end

endmodule

// File: rtl/control_multiciclo.sv
// Multicycle MIPS control FSM: Moore decode of the state, with the FETCH
// write enables qualified by the memory ready handshake.
module control_multiciclo
    import control_multiciclo_pkg::*;
#(
    parameter int ANCHO_OP   = 6,
    parameter int ANCHO_CONT = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ANCHO_OP-1:0]   codigo_operacion,
    input  logic                  mem_listo,
    output logic                  pc_escribir,
    output logic                  pc_escribir_cond,
    output logic                  i_o_d,
    output logic                  mem_leer,
    output logic                  mem_escribir,
    output logic                  ir_escribir,
    output logic                  mem_a_reg,
    output logic                  destino_reg,
    output logic                  reg_escribir,
    output logic                  alu_fuente_a,
    output logic [1:0]            alu_fuente_b,
    output logic [1:0]            alu_operacion,
    output logic [1:0]            pc_fuente,
    output logic                  instr_completa,
    output logic                  op_invalida,
    output logic [ANCHO_CONT-1:0] instr_contador
);

    logic [3:0] estado_r;
    logic [3:0] estado_sig_s;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            estado_r <= ST_INICIO;
        end else begin
            estado_r <= estado_sig_s;
        end
    end

    // Next-state logic; unused encodings recover through INICIO.
    always_comb begin
        estado_sig_s = ST_INICIO;
        case (estado_r)
            ST_INICIO: estado_sig_s = ST_FETCH;
            ST_FETCH: begin
                if (mem_listo) estado_sig_s = ST_DECODE;
                else           estado_sig_s = ST_FETCH;
            end
            ST_DECODE: begin
                case (codigo_operacion)
                    OP_TIPO_R:    estado_sig_s = ST_EJEC;
                    OP_LW, OP_SW: estado_sig_s = ST_MEM_DIR;
                    OP_BEQ:       estado_sig_s = ST_RAMA;
                    OP_J:         estado_sig_s = ST_SALTO;
                    default:      estado_sig_s = ST_FETCH;
                endcase
            end
            ST_MEM_DIR: begin
                if (codigo_operacion == OP_LW)      estado_sig_s = ST_MEM_LEER;
                else if (codigo_operacion == OP_SW) estado_sig_s = ST_MEM_ESCR;
                else                                estado_sig_s = ST_FETCH;
            end
            ST_MEM_LEER: begin
                if (mem_listo) estado_sig_s = ST_MEM_WB;
                else           estado_sig_s = ST_MEM_LEER;
            end
            ST_MEM_WB: estado_sig_s = ST_FETCH;
            ST_MEM_ESCR: begin
                if (mem_listo) estado_sig_s = ST_FETCH;
                else           estado_sig_s = ST_MEM_ESCR;
            end
            ST_EJEC:   estado_sig_s = ST_ALU_WB;
            ST_ALU_WB: estado_sig_s = ST_FETCH;
            ST_RAMA:   estado_sig_s = ST_FETCH;
            ST_SALTO:  estado_sig_s = ST_FETCH;
            default:   estado_sig_s = ST_INICIO;
        endcase
    end

    // Output decode; everything not named for a state stays 0.
    always_comb begin
        pc_escribir      = 1'b0;
        pc_escribir_cond = 1'b0;
        i_o_d            = 1'b0;
        mem_leer         = 1'b0;
        mem_escribir     = 1'b0;
        ir_escribir      = 1'b0;
        mem_a_reg        = 1'b0;
        destino_reg      = 1'b0;
        reg_escribir     = 1'b0;
        alu_fuente_a     = 1'b0;
        alu_fuente_b     = FB_REG_B;
        alu_operacion    = ALU_SUMA;
        pc_fuente        = PCF_ALU;
        instr_completa   = 1'b0;
        op_invalida      = 1'b0;
        case (estado_r)
            ST_FETCH: begin
                mem_leer     = 1'b1;
                alu_fuente_b = FB_CUATRO;
                if (mem_listo) begin
                    ir_escribir = 1'b1;
                    pc_escribir = 1'b1;
                end else begin
                    ir_escribir = 1'b0;
                    pc_escribir = 1'b0;
                end
            end
            ST_DECODE: begin
                // Branch target is precomputed into ALUOut here.
                alu_fuente_b = FB_INMED_DESP;
                if (opcode_valido(codigo_operacion)) op_invalida = 1'b0;
                else                                 op_invalida = 1'b1;
            end
            ST_MEM_DIR: begin
                alu_fuente_a = 1'b1;
                alu_fuente_b = FB_INMED;
            end
            ST_MEM_LEER: begin
                mem_leer = 1'b1;
                i_o_d    = 1'b1;
            end
            ST_MEM_WB: begin
                reg_escribir   = 1'b1;
                mem_a_reg      = 1'b1;
                instr_completa = 1'b1;
            end
            ST_MEM_ESCR: begin
                mem_escribir   = 1'b1;
                i_o_d          = 1'b1;
                instr_completa = mem_listo;
            end
            ST_EJEC: begin
                alu_fuente_a  = 1'b1;
                alu_operacion = ALU_FUNCT;
            end
            ST_ALU_WB: begin
                reg_escribir   = 1'b1;
                destino_reg    = 1'b1;
                instr_completa = 1'b1;
            end
            ST_RAMA: begin
                alu_fuente_a     = 1'b1;
                alu_operacion    = ALU_RESTA;
                pc_escribir_cond = 1'b1;
                pc_fuente        = PCF_ALUOUT;
                instr_completa   = 1'b1;
            end
            ST_SALTO: begin
                pc_escribir    = 1'b1;
                pc_fuente      = PCF_SALTO;
                instr_completa = 1'b1;
            end
            default: begin
                instr_completa = 1'b0;
            end
        endcase
    end

    contador_instrucciones #(
        .ANCHO_CONT(ANCHO_CONT)
    ) u_contador (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (instr_completa),
        .cuenta (instr_contador)
    );

endmodule

// File: tb/tb_control_multiciclo.sv
// Randomized self-checking bench: expected control vectors come from a
// per-phase table of the instruction sequencing rules.
module tb_control_multiciclo;

    typedef struct packed {
        logic       pc_w;
        logic       pc_wc;
        logic       iod;
        logic       mr;
        logic       mw;
        logic       irw;
        logic       m2r;
        logic       dst;
        logic       rw;
        logic       fa;
        logic [1:0] fb;
        logic [1:0] aop;
        logic [1:0] pcf;
        logic       done;
        logic       inv;
    } ctl_t;

    localparam int PH_IDLE = 0, PH_FETCH = 1, PH_DECODE = 2, PH_DECODE_BAD = 3,
                   PH_MEMDIR = 4, PH_MEMRD = 5, PH_MEMWB = 6, PH_MEMWR = 7,
                   PH_EXEC = 8, PH_ALUWB = 9, PH_BRANCH = 10, PH_JUMP = 11;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] codigo = 6'd0;
    logic       mem_listo = 1'b0;

    logic a_pcw, a_pcwc, a_iod, a_mr, a_mw, a_irw, a_m2r, a_dst, a_rw, a_fa, a_done, a_inv;
    logic [1:0] a_fb, a_aop, a_pcf;
    logic [15:0] cuenta16;
    logic b_pcw, b_pcwc, b_iod, b_mr, b_mw, b_irw, b_m2r, b_dst, b_rw, b_fa, b_done, b_inv;
    logic [1:0] b_fb, b_aop, b_pcf;
    logic [3:0] cuenta4;

    ctl_t obs, obs4;
    assign obs  = {a_pcw, a_pcwc, a_iod, a_mr, a_mw, a_irw, a_m2r, a_dst, a_rw, a_fa,
                   a_fb, a_aop, a_pcf, a_done, a_inv};
    assign obs4 = {b_pcw, b_pcwc, b_iod, b_mr, b_mw, b_irw, b_m2r, b_dst, b_rw, b_fa,
                   b_fb, b_aop, b_pcf, b_done, b_inv};

    int checks = 0, failures = 0;
    int model_cnt = 0;
    int steps, fin_step, rd_cycles, wr_cycles, rw_cycles;

    always #5 clk = ~clk;

    control_multiciclo dut (
        .clk(clk), .rst_n(rst_n), .codigo_operacion(codigo), .mem_listo(mem_listo),
        .pc_escribir(a_pcw), .pc_escribir_cond(a_pcwc), .i_o_d(a_iod), .mem_leer(a_mr),
        .mem_escribir(a_mw), .ir_escribir(a_irw), .mem_a_reg(a_m2r), .destino_reg(a_dst),
        .reg_escribir(a_rw), .alu_fuente_a(a_fa), .alu_fuente_b(a_fb), .alu_operacion(a_aop),
        .pc_fuente(a_pcf), .instr_completa(a_done), .op_invalida(a_inv),
        .instr_contador(cuenta16)
    );

    control_multiciclo #(.ANCHO_OP(6), .ANCHO_CONT(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .codigo_operacion(codigo), .mem_listo(mem_listo),
        .pc_escribir(b_pcw), .pc_escribir_cond(b_pcwc), .i_o_d(b_iod), .mem_leer(b_mr),
        .mem_escribir(b_mw), .ir_escribir(b_irw), .mem_a_reg(b_m2r), .destino_reg(b_dst),
        .reg_escribir(b_rw), .alu_fuente_a(b_fa), .alu_fuente_b(b_fb), .alu_operacion(b_aop),
        .pc_fuente(b_pcf), .instr_completa(b_done), .op_invalida(b_inv),
        .instr_contador(cuenta4)
    );

    // Control vector required in each instruction phase.
    function automatic ctl_t expect_for(input int ph, input logic listo);
        ctl_t c;
        c = '0;
        case (ph)
            PH_FETCH:      begin c.mr = 1'b1; c.fb = 2'b01; c.irw = listo; c.pc_w = listo; end
            PH_DECODE:     c.fb = 2'b11;
            PH_DECODE_BAD: begin c.fb = 2'b11; c.inv = 1'b1; end
            PH_MEMDIR:     begin c.fa = 1'b1; c.fb = 2'b10; end
            PH_MEMRD:      begin c.mr = 1'b1; c.iod = 1'b1; end
            PH_MEMWB:      begin c.rw = 1'b1; c.m2r = 1'b1; c.done = 1'b1; end
            PH_MEMWR:      begin c.mw = 1'b1; c.iod = 1'b1; c.done = listo; end
            PH_EXEC:       begin c.fa = 1'b1; c.aop = 2'b10; end
            PH_ALUWB:      begin c.rw = 1'b1; c.dst = 1'b1; c.done = 1'b1; end
            PH_BRANCH:     begin c.fa = 1'b1; c.aop = 2'b01; c.pc_wc = 1'b1; c.pcf = 2'b01; c.done = 1'b1; end
            PH_JUMP:       begin c.pc_w = 1'b1; c.pcf = 2'b10; c.done = 1'b1; end
            default:       c = '0;
        endcase
        return c;
    endfunction

    function automatic int base_latency(input logic [5:0] op);
        case (op)
            6'b000000: return 4;
            6'b100011: return 5;
            6'b101011: return 4;
            6'b000100: return 3;
            6'b000010: return 3;
            default:   return 2;
        endcase
    endfunction

    function automatic logic is_legal(input logic [5:0] op);
        return (op == 6'b000000) || (op == 6'b100011) || (op == 6'b101011) ||
               (op == 6'b000100) || (op == 6'b000010);
    endfunction

    task automatic drive_cycle(input int ph, input logic [5:0] op, input logic listo, input logic rst);
        ctl_t e;
        @(negedge clk);
        rst_n = rst; codigo = op; mem_listo = listo;
        #1;
        e = expect_for(ph, listo);
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL ctl phase=%0d got=%b expected=%b", ph, obs, e);
        end
        checks++;
        if (obs4 !== e) begin
            failures++;
            $display("FAIL ctl4 phase=%0d got=%b expected=%b", ph, obs4, e);
        end
        checks++;
        if (cuenta16 !== 16'(model_cnt)) begin
            failures++;
            $display("FAIL count16 got=%0d expected=%0d", cuenta16, model_cnt);
        end
        checks++;
        if (cuenta4 !== 4'(model_cnt % 16)) begin
            failures++;
            $display("FAIL count4 got=%0d expected=%0d", cuenta4, model_cnt % 16);
        end
        steps++;
        if ((obs.done || obs.inv) && fin_step == 0) fin_step = steps;
        if (obs.mr && obs.iod) rd_cycles++;
        if (obs.mw) wr_cycles++;
        if (obs.rw) rw_cycles++;
        if (!rst) model_cnt = 0;
        else if (e.done) model_cnt = (model_cnt + 1) % 65536;
    endtask

    task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
        int lat;
        steps = 0; fin_step = 0; rd_cycles = 0; wr_cycles = 0; rw_cycles = 0;
        for (int i = 0; i < fw; i++) drive_cycle(PH_FETCH, 6'($urandom), 1'b0, 1'b1);
        drive_cycle(PH_FETCH, 6'($urandom), 1'b1, 1'b1);
        case (op)
            6'b000000: begin
                drive_cycle(PH_DECODE, op, 1'($urandom), 1'b1);
                drive_cycle(PH_EXEC, op, 1'($urandom), 1'b1);
                drive_cycle(PH_ALUWB, op, 1'($urandom), 1'b1);
            end
            6'b100011: begin
                drive_cycle(PH_DECODE, op, 1'($urandom), 1'b1);
                drive_cycle(PH_MEMDIR, op, 1'($urandom), 1'b1);
                for (int i = 0; i < mw; i++) drive_cycle(PH_MEMRD, op, 1'b0, 1'b1);
                drive_cycle(PH_MEMRD, op, 1'b1, 1'b1);
                drive_cycle(PH_MEMWB, op, 1'($urandom), 1'b1);
            end
            6'b101011: begin
                drive_cycle(PH_DECODE, op, 1'($urandom), 1'b1);
                drive_cycle(PH_MEMDIR, op, 1'($urandom), 1'b1);
                for (int i = 0; i < mw; i++) drive_cycle(PH_MEMWR, op, 1'b0, 1'b1);
                drive_cycle(PH_MEMWR, op, 1'b1, 1'b1);
            end
            6'b000100: begin
                drive_cycle(PH_DECODE, op, 1'($urandom), 1'b1);
                drive_cycle(PH_BRANCH, op, 1'($urandom), 1'b1);
            end
            6'b000010: begin
                drive_cycle(PH_DECODE, op, 1'($urandom), 1'b1);
                drive_cycle(PH_JUMP, op, 1'($urandom), 1'b1);
            end
            default: drive_cycle(PH_DECODE_BAD, op, 1'($urandom), 1'b1);
        endcase
        lat = base_latency(op) + fw + (((op == 6'b100011) || (op == 6'b101011)) ? mw : 0);
        checks++;
        if (fin_step !== lat) begin
            failures++;
            $display("FAIL latency op=%b got=%0d expected=%0d", op, fin_step, lat);
        end
    endtask

    task automatic test_reset();
        drive_cycle(PH_IDLE, 6'd0, 1'b1, 1'b0);
        drive_cycle(PH_IDLE, 6'd0, 1'b1, 1'b0);
        drive_cycle(PH_IDLE, 6'd0, 1'b1, 1'b1);
    endtask

    task automatic test_rtype();
        run_instr(6'b000000, 0, 0);
        checks++;
        if (rw_cycles !== 1) begin
            failures++;
            $display("FAIL rtype_regwrite_cycles got=%0d expected=1", rw_cycles);
        end
        @(posedge clk); #1;
        checks++;
        if (cuenta16 !== 16'd1) begin
            failures++;
            $display("FAIL rtype_count got=%0d expected=1", cuenta16);
        end
    endtask

    task automatic test_lw_wait();
        run_instr(6'b100011, 0, 3);
        checks++;
        if (rd_cycles !== 4) begin
            failures++;
            $display("FAIL lw_read_cycles got=%0d expected=4", rd_cycles);
        end
    endtask

    task automatic test_sw_beq();
        run_instr(6'b101011, 0, 0);
        checks++;
        if (wr_cycles !== 1) begin
            failures++;
            $display("FAIL sw_write_cycles got=%0d expected=1", wr_cycles);
        end
        run_instr(6'b000100, 0, 0);
        @(posedge clk); #1;
        checks++;
        if (cuenta16 !== 16'd4) begin
            failures++;
            $display("FAIL sw_beq_count got=%0d expected=4", cuenta16);
        end
    endtask

    task automatic test_jump();
        run_instr(6'b000010, 0, 0);
        drive_cycle(PH_FETCH, 6'($urandom), 1'b0, 1'b1);
    endtask

    task automatic test_illegal();
        run_instr(6'b111111, 1, 0);
        @(posedge clk); #1;
        checks++;
        if (cuenta16 !== 16'd5) begin
            failures++;
            $display("FAIL illegal_count got=%0d expected=5", cuenta16);
        end
    endtask

    task automatic test_reset_mid_wait();
        drive_cycle(PH_FETCH, 6'd0, 1'b1, 1'b1);
        drive_cycle(PH_DECODE, 6'b100011, 1'b0, 1'b1);
        drive_cycle(PH_MEMDIR, 6'b100011, 1'b0, 1'b1);
        drive_cycle(PH_MEMRD, 6'b100011, 1'b0, 1'b1);
        drive_cycle(PH_MEMRD, 6'b100011, 1'b0, 1'b0);
        drive_cycle(PH_IDLE, 6'b100011, 1'b1, 1'b1);
        checks++;
        if (cuenta16 !== 16'd0) begin
            failures++;
            $display("FAIL midreset_count got=%0d expected=0", cuenta16);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 16; i++) run_instr(6'b000010, 0, 0);
        @(posedge clk); #1;
        checks++;
        if (cuenta4 !== 4'd0) begin
            failures++;
            $display("FAIL wrap4 got=%0d expected=0", cuenta4);
        end
        checks++;
        if (cuenta16 !== 16'd16) begin
            failures++;
            $display("FAIL wrap16 got=%0d expected=16", cuenta16);
        end
    endtask

    task automatic test_random();
        logic [5:0] op;
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 5))
                0: op = 6'b000000;
                1: op = 6'b100011;
                2: op = 6'b101011;
                3: op = 6'b000100;
                4: op = 6'b000010;
                default: begin
                    op = 6'($urandom);
                    while (is_legal(op)) op = 6'($urandom);
                end
            endcase
            run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3));
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_wait();
        test_sw_beq();
        test_jump();
        test_illegal();
        test_reset_mid_wait();
        test_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
